// File: rtl/key_bounce_gen_pkg.sv
// key_bounce_gen_pkg
// Shared types and constants for the key-contact emulator:
//   state_e      - generator FSM states
//   LFSR_TAPS    - feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   DEFAULT_SEED - reset / fallback LFSR value
//   cnt_width()  - bits needed to hold a counter value 0..max_val
package key_bounce_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        SETTLE
    } state_e;

    // Bit positions 15,13,12,10 correspond to taps 16,14,13,11 (1-based).
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_bounce_gen_if.sv
// key_bounce_gen_if
// Command/status bundle of the key-contact emulator.
//   req      - single-cycle start strobe        (master -> slave)
//   level_in - target key level, taken with req (master -> slave)
//   busy     - run in progress                  (slave -> master)
//   done     - one-cycle end-of-settle pulse    (slave -> master)
//   key_out  - emulated bouncy key line         (slave -> master)
interface key_bounce_gen_if;
    logic req;
    logic level_in;
    logic busy;
    logic done;
    logic key_out;

    modport master (
        output req,
        output level_in,
        input  busy,
        input  done,
        input  key_out
    );

    modport slave (
        input  req,
        input  level_in,
        output busy,
        output done,
        output key_out
    );
endinterface

// File: rtl/key_bounce_gen_lfsr16.sv
// lfsr16
// Free-running 16-bit Fibonacci LFSR, shifting left with feedback into bit 0.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (loads SEED)
//   load       - replace the register with load_val instead of shifting
//   load_val   - value taken when load is high
//   q          - low Q_W bits of the current register value
module lfsr16
    import key_bounce_gen_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED,
    parameter int unsigned Q_W  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [15:0]    load_val,
    output logic [Q_W-1:0] q
);

    logic [15:0] lfsr_d;
    logic [15:0] lfsr_q;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        if (load) begin
            lfsr_d = load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q[Q_W-1:0];

endmodule

// File: rtl/key_bounce_gen.sv
// key_bounce_gen
// Key-contact emulator: on an accepted req it drives key_out through
// BOUNCE_COUNT pseudo-random-width toggles (each gap 1..2^GAP_W cycles),
// forces the requested level, holds it for SETTLE_CYCLES, then pulses done.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - key_bounce_gen_if.slave (req, level_in, busy, done, key_out)
//   seed_we    - (KEY_BOUNCE_GEN_SEED_LOAD_EN only) load LFSR next cycle
//   seed_in    - (KEY_BOUNCE_GEN_SEED_LOAD_EN only) seed; zero selects LFSR_SEED
module key_bounce_gen
    import key_bounce_gen_pkg::*;
#(
    parameter int unsigned BOUNCE_COUNT  = 50,
    parameter int unsigned GAP_W         = 12,
    parameter int unsigned SETTLE_CYCLES = 1250000,
    parameter bit          IDLE_LEVEL    = 1'b1,
    parameter logic [15:0] LFSR_SEED     = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    key_bounce_gen_if.slave  bus
`ifdef KEY_BOUNCE_GEN_SEED_LOAD_EN
    ,
    input  logic             seed_we,
    input  logic [15:0]      seed_in
`endif
);

    localparam int unsigned GAP_CW = cnt_width(2 ** GAP_W);
    localparam int unsigned SET_CW = cnt_width(SETTLE_CYCLES);
    localparam int unsigned TOG_CW = cnt_width(BOUNCE_COUNT);

    localparam logic [SET_CW-1:0] SETTLE_LOAD = SET_CW'(SETTLE_CYCLES);
    localparam logic [TOG_CW-1:0] LAST_TOGGLE = TOG_CW'(BOUNCE_COUNT - 1);

    state_e              state_d, state_q;
    logic                key_d, key_q;
    logic                busy_d, busy_q;
    logic                done_d, done_q;
    logic                tgt_d, tgt_q;
    logic [GAP_CW-1:0]   gap_d, gap_q;
    logic [TOG_CW-1:0]   cnt_d, cnt_q;
    logic [SET_CW-1:0]   settle_d, settle_q;

    logic                lfsr_load;
    logic [15:0]         lfsr_load_val;
    logic [GAP_W-1:0]    lfsr_low;
    logic [GAP_CW-1:0]   gap_load;

`ifdef KEY_BOUNCE_GEN_SEED_LOAD_EN
    assign lfsr_load     = seed_we;
    assign lfsr_load_val = (seed_in == '0) ? LFSR_SEED : seed_in;
`else
    assign lfsr_load     = 1'b0;
    assign lfsr_load_val = LFSR_SEED;
`endif

    lfsr16 #(
        .SEED (LFSR_SEED),
        .Q_W  (GAP_W)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .q        (lfsr_low)
    );

    assign gap_load = GAP_CW'(lfsr_low) + GAP_CW'(1);

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tgt_d    = tgt_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    tgt_d  = bus.level_in;
                    busy_d = 1'b1;
                    if (bus.level_in == key_q) begin
                        settle_d = SETTLE_LOAD;
                        state_d  = SETTLE;
                    end else begin
                        gap_d   = gap_load;
                        cnt_d   = '0;
                        state_d = BOUNCE;
                    end
                end
            end
            BOUNCE: begin
                if (gap_q == GAP_CW'(1)) begin
                    if (cnt_q == LAST_TOGGLE) begin
                        // Final bounce: the target level replaces the toggle.
                        key_d    = tgt_q;
                        settle_d = SETTLE_LOAD;
                        state_d  = SETTLE;
                    end else begin
                        key_d = ~key_q;
                        cnt_d = cnt_q + TOG_CW'(1);
                        gap_d = gap_load;
                    end
                end else begin
                    gap_d = gap_q - GAP_CW'(1);
                end
            end
            SETTLE: begin
                if (settle_q == SET_CW'(1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    settle_d = settle_q - SET_CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            key_q    <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tgt_q    <= IDLE_LEVEL;
            gap_q    <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tgt_q    <= tgt_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.key_out = key_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// tb_key_bounce_gen
// Self-checking bench for key_bounce_gen (BOUNCE_COUNT=4, GAP_W=4,
// SETTLE_CYCLES=16). A schedule model predicts key_out/busy/done every cycle;
// directed runs pin the model with hand-computed gap timings.
// Seed-load checks are built when KEY_BOUNCE_GEN_SEED_LOAD_EN is defined.
module tb_key_bounce_gen;

    localparam int BC = 4;
    localparam int GW = 4;
    localparam int SC = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    key_bounce_gen_if bus ();

`ifdef KEY_BOUNCE_GEN_SEED_LOAD_EN
    logic        seed_we = 1'b0;
    logic [15:0] seed_in = '0;
`endif

    key_bounce_gen #(
        .BOUNCE_COUNT  (BC),
        .GAP_W         (GW),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus)
`ifdef KEY_BOUNCE_GEN_SEED_LOAD_EN
        ,
        .seed_we (seed_we),
        .seed_in (seed_in)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model tracks absolute edge numbers since reset release. On an
    // accepted request it precomputes every bounce instant from the LFSR
    // sequence; the last instant lands the target level.
    logic [15:0] m_lfsr = 16'hACE1;
    logic        m_key  = 1'b1;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_tgt  = 1'b1;
    int          m_edge = 0;
    int          m_done_edge = 0;
    int          m_events[$];

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int gap_of(input logic [15:0] v);
        return int'(v[GW-1:0]) + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr = 16'hACE1;
            m_key  = 1'b1;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_edge = 0;
            m_events.delete();
        end else begin
            logic [15:0] l;
            int          t;
            m_done = 1'b0;
            if (m_busy && m_edge == m_done_edge) begin
                m_done = 1'b1;
                m_busy = 1'b0;
            end else if (m_busy && m_events.size() > 0 && m_edge == m_events[0]) begin
                void'(m_events.pop_front());
                m_key = (m_events.size() == 0) ? m_tgt : ~m_key;
            end else if (!m_busy && bus.req) begin
                m_tgt  = bus.level_in;
                m_busy = 1'b1;
                if (m_tgt == m_key) begin
                    m_done_edge = m_edge + SC;
                end else begin
                    l = m_lfsr;
                    t = m_edge;
                    for (int k = 0; k < BC; k++) begin
                        int g;
                        g = gap_of(l);
                        t += g;
                        for (int s = 0; s < g; s++) l = lfsr_next(l);
                        m_events.push_back(t);
                    end
                    m_done_edge = t + SC;
                end
            end
`ifdef KEY_BOUNCE_GEN_SEED_LOAD_EN
            if (seed_we) m_lfsr = (seed_in == 16'h0) ? 16'hACE1 : seed_in;
            else         m_lfsr = lfsr_next(m_lfsr);
`else
            m_lfsr = lfsr_next(m_lfsr);
`endif
            m_edge++;
        end
    end

    // Single compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("key_out", int'(bus.key_out), int'(m_key));
        chk("busy",    int'(bus.busy),    int'(m_busy));
        chk("done",    int'(bus.done),    int'(m_done));
    end

    // Event monitors, sampled 1 time unit after the active edge.
    int   done_cnt = 0;
    int   edges    = 0;
    logic prev_key = 1'b1;
    always @(posedge clk) begin
        #1;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.key_out !== prev_key) edges++;
        prev_key = bus.key_out;
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_req(input logic lvl);
        bus.level_in = lvl;
        bus.req      = 1'b1;
        @(negedge clk);
        bus.req      = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int waited);
        waited = 0;
        while (bus.done !== 1'b1 && waited < max_cyc) begin
            @(negedge clk);
            waited++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
        end
    endtask

    task automatic wait_key_change(input int max_cyc, output int waited);
        logic start;
        start  = bus.key_out;
        waited = 0;
        while (bus.key_out === start && waited < max_cyc) begin
            @(negedge clk);
            waited++;
        end
        if (bus.key_out === start) begin
            checks++;
            errors++;
            $display("FAIL key_change_timeout: key_out stuck at %0d", start);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int pulses;
        bus.req      = 1'b0;
        bus.level_in = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Press, accepted on the first edge after release (LFSR = ACE1).
        // Gaps: ACE1 -> 2 cycles, then 59C3 -> B387 gives 8 cycles.
        edges    = 0;
        done_cnt = 0;
        pulse_req(1'b0);
        chk("press_busy", int'(bus.busy), 1);
        wait_key_change(40, w);
        chk("press_first_gap", w, 2);
        wait_key_change(40, w);
        chk("press_second_gap", w, 8);
        wait_done(200, w);
        chk("press_final_level", int'(bus.key_out), 0);
        @(negedge clk);
        chk("press_busy_clear", int'(bus.busy), 0);
        // With an even count the fourth bounce coincides with the forced level.
        chk("press_edges", edges, 3);
        chk("press_done_count", done_cnt, 1);

        // Release mirrors the press.
        edges    = 0;
        done_cnt = 0;
        pulse_req(1'b1);
        wait_done(200, w);
        chk("release_final_level", int'(bus.key_out), 1);
        @(negedge clk);
        chk("release_edges", edges, 3);
        chk("release_done_count", done_cnt, 1);

        // Same level: no bounce, done exactly SC cycles after acceptance.
        edges    = 0;
        done_cnt = 0;
        pulse_req(1'b1);
        wait_done(200, w);
        chk("same_level_latency", w, SC);
        @(negedge clk);
        chk("same_level_edges", edges, 0);

        // Busy reject: a second request during the bounce is dropped.
        edges    = 0;
        done_cnt = 0;
        pulse_req(1'b0);
        pulse_req(1'b1);
        wait_done(200, w);
        chk("reject_final_level", int'(bus.key_out), 0);
        repeat (20) @(negedge clk);
        chk("reject_edges", edges, 3);
        chk("reject_done_count", done_cnt, 1);

        // Abort during SETTLE with an asynchronous mid-cycle reset.
        pulse_req(1'b1);
        w = 0;
        while (!(m_busy && m_events.size() == 0) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("abort_reached_settle", int'(m_busy && m_events.size() == 0), 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_key", int'(bus.key_out), 1);
        chk("async_reset_busy", int'(bus.busy), 0);
        chk("async_reset_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        repeat (30) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);

`ifdef KEY_BOUNCE_GEN_SEED_LOAD_EN
        // A zero seed falls back to ACE1, so the next gap is 2 again.
        seed_we = 1'b1;
        seed_in = 16'h0000;
        @(negedge clk);
        seed_we = 1'b0;
        pulse_req(1'b0);
        wait_key_change(40, w);
        chk("seed_zero_gap", w, 2);
        wait_done(200, w);
`endif

        // Randomized runs, with stray requests while busy.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
`ifdef KEY_BOUNCE_GEN_SEED_LOAD_EN
            if ($urandom_range(0, 3) == 0) begin
                seed_we = 1'b1;
                seed_in = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                @(negedge clk);
                seed_we = 1'b0;
            end
`endif
            pulse_req(1'($urandom_range(0, 1)));
            pulses = $urandom_range(0, 2);
            w = 0;
            while (bus.done !== 1'b1 && w < 300) begin
                if (pulses > 0 && bus.busy === 1'b1 && $urandom_range(0, 7) == 0) begin
                    bus.req      = 1'b1;
                    bus.level_in = 1'($urandom_range(0, 1));
                    pulses--;
                end
                @(negedge clk);
                bus.req = 1'b0;
                w++;
            end
            if (bus.done !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL random_done_timeout: run %0d", n);
            end
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
